// File: rtl/multi_timer_if.sv
// Peripheral bus between a host and multi_timer: one access per clk while cs is high.
// Read data on DO is registered inside the timer block.
interface multi_timer_if #(
  parameter int AW = 5
);
  logic [AW-1:0] AD;
  logic [7:0]    DI;
  logic [7:0]    DO;
  logic          rw;
  logic          cs;

  modport master (output AD, DI, rw, cs, input DO);
  modport slave  (input AD, DI, rw, cs, output DO);
endinterface

// File: rtl/multi_timer.sv
// NCH independent WIDTH-bit tick-driven timers with one-shot mode, W1C interrupt flags,
// snapshot-based coherent multi-byte reads and a shared pending bitmap.
module multi_timer #(
  parameter int NCH   = 4,
  parameter int WIDTH = 24,
  parameter int AW    = (3 + $clog2(NCH) < 4) ? 4 : 3 + $clog2(NCH)
) (
  input  logic         clk,
  input  logic         rst,
  multi_timer_if.slave bus,
  input  logic         tick,
  output logic         irq
);
  localparam int CHW = AW - 3;
  localparam int NB  = WIDTH / 8;

  logic [WIDTH-1:0] cnt    [NCH];
  logic [WIDTH-1:0] reload [NCH];
  logic [WIDTH-1:0] shadow [NCH];
  logic [NCH-1:0]   flag, ien, mode, run;

  logic [CHW-1:0]   ch_sel;
  logic [2:0]       reg_sel;
  logic             ch_ok, rd_en, wr_en;
  logic [NCH-1:0]   ctrl_wr, snap, hit;
  logic [WIDTH-1:0] sel_live, sel_shadow;
  logic [7:0]       sel_ctrl, pend, rdata;

  assign ch_sel  = bus.AD[AW-1:3];
  assign reg_sel = bus.AD[2:0];
  assign ch_ok   = (int'(ch_sel) < NCH);
  assign rd_en   = bus.cs & bus.rw & ch_ok;
  assign wr_en   = bus.cs & ~bus.rw & ch_ok;

  // Only registered state feeds irq, so bus inputs cannot glitch it.
  assign irq = |(flag & ien);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pend       = '0;
    pend[NCH-1:0] = flag;
    sel_live   = '0;
    sel_shadow = '0;
    sel_ctrl   = '0;
    ctrl_wr    = '0;
    snap       = '0;
    hit        = '0;
    for (int c = 0; c < NCH; c++) begin
      ctrl_wr[c] = wr_en && (ch_sel == CHW'(c)) && (reg_sel == 3'd0);
      snap[c]    = rd_en && (ch_sel == CHW'(c)) && (reg_sel == 3'd2);
      hit[c]     = run[c] && tick && (cnt[c] >= reload[c]);
      if (ch_sel == CHW'(c)) begin
        sel_live   = run[c] ? cnt[c] : reload[c];
        sel_shadow = shadow[c];
        sel_ctrl   = {flag[c], ien[c], 4'b0000, mode[c], run[c]};
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (ch_ok) begin
      case (reg_sel)
        3'd0:              rdata = sel_ctrl;
        3'd2:              rdata = sel_live[7:0];
        3'd3, 3'd4, 3'd5: begin
          for (int b = 1; b < NB; b++)
            if (reg_sel == 3'(b + 2)) rdata = sel_shadow[8*b +: 8];
        end
        3'd6:              rdata = pend;
        default:           rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the per-channel arrays are plain flops, not RAM, so every entry is reset explicitly.
      for (int c = 0; c < NCH; c++) begin
        cnt[c]    <= '0;
        reload[c] <= '0;
        shadow[c] <= '0;
      end
      flag   <= '0;
      ien    <= '0;
      mode   <= '0;
      run    <= '0;
      bus.DO <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments below deliberately override earlier ones.
      if (bus.cs && bus.rw) bus.DO <= rdata;
      for (int c = 0; c < NCH; c++) begin
        if (snap[c]) shadow[c] <= run[c] ? cnt[c] : reload[c];
        for (int b = 0; b < NB; b++)
          if (wr_en && (ch_sel == CHW'(c)) && (reg_sel == 3'(b + 2)))
            reload[c][8*b +: 8] <= bus.DI;

        if (run[c] && tick) cnt[c] <= hit[c] ? '0 : cnt[c] + WIDTH'(1);
        if (hit[c] && mode[c]) run[c] <= 1'b0;

        // A CTRL write lands after the counting update so it wins over a one-shot auto-stop.
        if (ctrl_wr[c]) begin
          ien[c]  <= bus.DI[6];
          mode[c] <= bus.DI[1];
          run[c]  <= bus.DI[0];
          if (bus.DI[0] && !run[c]) cnt[c] <= '0;
        end

        if (hit[c])                         flag[c] <= 1'b1;
        else if (ctrl_wr[c] && bus.DI[7])   flag[c] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_multi_timer.sv
// Scenario bench for multi_timer (NCH=3, WIDTH=24): read expectations are queued when a
// read is issued and popped when DO returns the data one clk later.
module tb_multi_timer;
  localparam int NCH = 3;
  localparam int WIDTH = 24;
  localparam int AW = 5;

  logic clk, rst, tick, irq;
  int n_checks, n_fail;
  logic [7:0] exp_q[$];

  multi_timer_if #(.AW(AW)) bus ();

  multi_timer #(.NCH(NCH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .tick (tick),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input int ch, input int ofs, input logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = AW'(ch * 8 + ofs); bus.DI = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; tick = 1'b0;
  endtask

  task automatic rd(input int ch, input int ofs, input logic [7:0] e, output logic [7:0] got);
    exp_q.push_back(e);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = AW'(ch * 8 + ofs);
    @(posedge clk); #1;
    bus.cs = 1'b0;
    got = bus.DO;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] got, e;
    wr(0, 0, 8'h41);
    ticks(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
    rd(0, 0, 8'hC1, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL pre_reset_ctrl: got %h expected %h", got, e); end
    rst = 1'b0; tick = 1'b1;
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = AW'(2); bus.DI = 8'h55;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; tick = 1'b0; bus.cs = 1'b0;
    n_checks++; if (bus.DO !== 8'h00) begin n_fail++; $display("FAIL reset_do: got %h expected 00", bus.DO); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    for (int c = 0; c < NCH; c++) begin
      rd(c, 0, 8'h00, got); e = exp_q.pop_front();
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL reset_ctrl ch%0d: got %h expected %h", c, got, e); end
    end
    rd(0, 2, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL reset_value: got %h expected %h", got, e); end
    rd(0, 6, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL reset_pend: got %h expected %h", got, e); end
  endtask

  task automatic test_periodic();
    logic [7:0] got, e;
    wr(1, 2, 8'd3);
    wr(1, 0, 8'h41);
    ticks(3);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL per_early_irq: got %b expected 0", irq); end
    ticks(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL per_irq: got %b expected 1", irq); end
    rd(1, 6, 8'h02, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL per_pend_ch1: got %h expected %h", got, e); end
    rd(0, 6, 8'h02, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL per_pend_ch0: got %h expected %h", got, e); end
    rd(1, 0, 8'hC1, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL per_ctrl: got %h expected %h", got, e); end
    ticks(2);
    wr(1, 0, 8'hC1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL per_w1c_irq: got %b expected 0", irq); end
    ticks(1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL per_cont_early: got %b expected 0", irq); end
    ticks(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL per_cont_event: got %b expected 1", irq); end
    wr(1, 0, 8'h80);
    rd(1, 0, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL per_stop_ctrl: got %h expected %h", got, e); end
  endtask

  task automatic test_one_shot();
    logic [7:0] got, e;
    logic seen;
    wr(0, 2, 8'd5);
    wr(0, 0, 8'h43);
    ticks(5);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL os_early_irq: got %b expected 0", irq); end
    ticks(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL os_irq: got %b expected 1", irq); end
    rd(0, 0, 8'hC2, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL os_ctrl: got %h expected %h", got, e); end
    wr(0, 0, 8'hC2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ticks(1);
      if (irq !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL os_no_retrigger: got %b expected 0", seen); end
    rd(0, 0, 8'h42, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL os_ctrl_after: got %h expected %h", got, e); end
  endtask

  task automatic test_coherent_read();
    logic [7:0] got, e;
    wr(2, 2, 8'h56); wr(2, 3, 8'h34); wr(2, 4, 8'h12); wr(2, 5, 8'hAA);
    rd(2, 2, 8'h56, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_reload_b0: got %h expected %h", got, e); end
    rd(2, 3, 8'h34, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_reload_b1: got %h expected %h", got, e); end
    rd(2, 4, 8'h12, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_reload_b2: got %h expected %h", got, e); end
    rd(2, 5, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_byte3: got %h expected %h", got, e); end
    wr(2, 0, 8'h01);
    ticks(255);
    rd(2, 2, 8'hFF, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_snap_b0: got %h expected %h", got, e); end
    ticks(5);
    rd(2, 3, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_snap_b1: got %h expected %h", got, e); end
    rd(2, 4, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_snap_b2: got %h expected %h", got, e); end
    rd(2, 2, 8'h04, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_live_b0: got %h expected %h", got, e); end
    rd(2, 3, 8'h01, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_live_b1: got %h expected %h", got, e); end
    wr(2, 0, 8'h00);
    rd(2, 2, 8'h56, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL coh_stopped_reload: got %h expected %h", got, e); end
  endtask

  task automatic test_reload_lowered();
    logic [7:0] got, e;
    wr(0, 2, 8'd100);
    wr(0, 0, 8'h41);
    ticks(10);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rl_early_irq: got %b expected 0", irq); end
    wr(0, 2, 8'd4);
    tick = 1'b1;
    wr(0, 0, 8'hC1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rl_set_wins: got %b expected 1", irq); end
    rd(0, 0, 8'hC1, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rl_ctrl: got %h expected %h", got, e); end
    wr(0, 0, 8'hC1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rl_w1c: got %b expected 0", irq); end
    ticks(4);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rl_cnt_zero: got %b expected 0", irq); end
    ticks(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rl_next_event: got %b expected 1", irq); end
    wr(0, 0, 8'h80);
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, e;
    wr(1, 2, 8'd2);
    wr(1, 0, 8'h43);
    ticks(2);
    tick = 1'b1;
    wr(1, 0, 8'h43);
    rd(1, 0, 8'hC3, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL b2b_write_wins: got %h expected %h", got, e); end
    wr(1, 0, 8'hC3);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL b2b_w1c: got %b expected 0", irq); end
    ticks(2);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got %b expected 0", irq); end
    ticks(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL b2b_event: got %b expected 1", irq); end
    rd(1, 0, 8'hC2, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL b2b_stopped: got %h expected %h", got, e); end
    wr(1, 0, 8'h80);
  endtask

  task automatic test_out_of_range();
    logic [7:0] got, e;
    for (int c = 0; c < NCH; c++) wr(c, 0, 8'h80);
    wr(3, 0, 8'hC3);
    wr(3, 2, 8'h77);
    ticks(3);
    rd(3, 0, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL oor_ctrl: got %h expected %h", got, e); end
    rd(3, 2, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL oor_value: got %h expected %h", got, e); end
    rd(3, 6, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL oor_pend: got %h expected %h", got, e); end
    for (int c = 0; c < NCH; c++) begin
      rd(c, 0, 8'h00, got); e = exp_q.pop_front();
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL oor_keep_ctrl ch%0d: got %h expected %h", c, got, e); end
    end
    rd(0, 2, 8'h04, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL oor_keep_reload0: got %h expected %h", got, e); end
    rd(1, 2, 8'h02, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL oor_keep_reload1: got %h expected %h", got, e); end
    rd(2, 2, 8'h56, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL oor_keep_reload2: got %h expected %h", got, e); end
    rd(0, 6, 8'h00, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL oor_pend_all: got %h expected %h", got, e); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oor_irq: got %b expected 0", irq); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; tick = 1'b0;
    bus.cs = 1'b0; bus.rw = 1'b0; bus.AD = '0; bus.DI = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_periodic();
    test_one_shot();
    test_coherent_read();
    test_reload_lowered();
    test_back_to_back();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
